fns_ftf_encoder_seq: RTL and testbench

//  Parametrised, multi-cycle Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder.

---
 rtl/fns_ftf_encoder_seq.sv | 189 ++++++++++++++++++
 tb/tb_fns_ftf_encoder_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_ftf_encoder_seq.sv
// Multi-cycle Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder.
// Resolves P code bits per cycle, MSB first, with valid/ready handshakes on both
// sides. A codeword decodes as the weighted sum of its set bits (weights f(k)).
module fns_ftf_encoder_seq #(
    parameter int unsigned DW = 12,
    parameter int unsigned M  = 18,
    parameter int unsigned P  = 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] datain,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  codeout,
    output logic          out_err
);

    // Fibonacci number f(k), f(1)=f(2)=1; elaboration-time only
    function automatic longint unsigned fib(input int unsigned k);
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        a = 64'd1;
        b = 64'd1;
        for (int unsigned i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return (k == 0) ? 64'd0 : b;
    endfunction

    // Remainder width covers the whole encodable range and the full input word
    localparam int unsigned FW   = $clog2(fib(M + 2));
    localparam int unsigned CW   = (FW > DW) ? FW : DW;
    localparam int unsigned LW   = CW + 1;
    localparam int unsigned ITER = (M + P - 1) / P;
    localparam int unsigned IW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned KW   = $clog2(M + 1);
    localparam int unsigned KN   = 1 << KW;

    // One past the largest encodable value; LW bits so it never wraps
    localparam logic [LW-1:0] F_LIM = LW'(fib(M + 2));

    // Reject illegal parameter sets at elaboration
    if (M < 2 || P < 1 || P > M) begin : g_bad_param
        $error("fns_ftf_encoder_seq: illegal parameters M=%0d P=%0d", M, P);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [IW-1:0]   it_q, it_n;
    logic [CW-1:0]   r_q, r_n;
    logic [M-1:0]    code_q, code_n;
    logic            valid_q, valid_n;
    logic            err_q, err_n;
    logic            run_q;

    logic [CW-1:0]   wt_k  [KN];
    logic [CW-1:0]   wt_k1 [KN];
    logic [CW-1:0]   r_t;
    logic [M-1:0]    code_t;
    logic [KW-1:0]   kk;
    int              hi;
    logic            accept;
    logic            in_err;

    // Constant weight tables: wt_k[k] = f(k), wt_k1[k] = f(k+1) for k in 1..M
    for (genvar g = 0; g < int'(KN); g++) begin : g_wt
        if (g >= 1 && g <= int'(M)) begin : g_used
            assign wt_k[g]  = CW'(fib(g));
            assign wt_k1[g] = CW'(fib(g + 1));
        end else begin : g_pad
            assign wt_k[g]  = '0;
            assign wt_k1[g] = '0;
        end
    end

    assign in_ready = run_q & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign in_err   = (LW'(datain) >= F_LIM);

    assign codeout   = code_q;
    assign out_valid = valid_q;
    assign out_err   = err_q;

    // Greedy slice: resolve bits hi down to max(1, hi-P+1) against the running remainder
    always_comb begin
        hi     = int'(M) - int'(it_q) * int'(P);
        r_t    = r_q;
        code_t = code_q;
        kk     = '0;
        for (int j = 0; j < int'(P); j++) begin
            if (hi - j >= 1) begin
                kk = KW'(hi - j);
                if (r_t >= wt_k1[kk]) begin
                    r_t    = r_t - wt_k[kk];
                    code_t = code_t | (M'(1) << (kk - KW'(1)));
                end
            end
        end
    end

    // Next-state and datapath-update logic
    always_comb begin
        state_n = state_q;
        it_n    = it_q;
        r_n     = r_q;
        code_n  = code_q;
        valid_n = valid_q;
        err_n   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_CALC;
                    it_n    = '0;
                    r_n     = in_err ? '0 : CW'(datain);
                    code_n  = '0;
                    err_n   = in_err;
                end
            end
            S_CALC: begin
                r_n    = r_t;
                code_n = code_t;
                if (it_q == IW'(ITER - 1)) begin
                    state_n = S_DONE;
                    it_n    = '0;
                    valid_n = 1'b1;
                end else begin
                    it_n = it_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                end
                // A new word may be accepted on the same edge the result leaves
                if (accept) begin
                    state_n = S_CALC;
                    it_n    = '0;
                    r_n     = in_err ? '0 : CW'(datain);
                    code_n  = '0;
                    err_n   = in_err;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            it_q    <= '0;
            r_q     <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            it_q    <= it_n;
            r_q     <= r_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    // Holds in_ready low until the first clock after reset release
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fns_ftf_encoder_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for fns_ftf_encoder_seq: four instances (P = 1, 4, 5, 18) at
// DW=13, M=18. Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_fns_ftf_encoder_seq;

    localparam int NI = 4;
    localparam int DW = 13;
    localparam int M  = 18;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    logic [NI-1:0]         in_valid;
    logic [NI-1:0]         in_ready;
    logic [NI-1:0]         out_valid;
    logic [NI-1:0]         out_ready;
    logic [NI-1:0]         out_err;
    logic [NI-1:0][DW-1:0] datain;
    logic [NI-1:0][M-1:0]  codeout;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fns_ftf_encoder_seq #(
            .DW(DW),
            .M (M),
            .P ((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 5 : 18)
        ) u_dut (
            .clock    (clock),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .datain   (datain[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .codeout  (codeout[g]),
            .out_err  (out_err[g])
        );
    end

    function automatic int iter_of(input int g);
        case (g)
            0:       return 18;
            1:       return 5;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int fibt(input int k);
        int a, b, t;
        a = 1;
        b = 1;
        for (int i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Reference greedy FNS encoder
    function automatic logic [M-1:0] model_enc(input int d);
        int r;
        logic [M-1:0] c;
        r = d;
        c = '0;
        if (d >= fibt(M + 2)) return '0;
        for (int k = M; k >= 1; k--) begin
            if (r >= fibt(k + 1)) begin
                c = c | (M'(1) << (k - 1));
                r = r - fibt(k);
            end
        end
        return c;
    endfunction

    // Decoder: weighted sum of set bits
    function automatic int wsum(input logic [M-1:0] c);
        int s;
        logic [M-1:0] t;
        s = 0;
        for (int k = 1; k <= M; k++) begin
            t = c >> (k - 1);
            if (t[0]) s = s + fibt(k);
        end
        return s;
    endfunction

    typedef struct {
        int           inst;
        logic [M-1:0] code;
        logic         err;
        int           data;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   last_acc;
    logic [NI-1:0] seen;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one word on instance g and wait for it to be accepted; leaves in_valid high
    task automatic send(input int g, input int d, input logic [M-1:0] code, input logic err);
        exp_t e;
        bit   done;
        done        = 1'b0;
        in_valid[g] = 1'b1;
        datain[g]   = DW'(d);
        for (int n = 0; n < 200 && !done; n++) begin
            #1;
            if (in_ready[g]) done = 1'b1;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            check($sformatf("accept_timeout_i%0d", g), 0, 1);
        end else begin
            last_acc = cyc;
            e.inst = g;
            e.code = code;
            e.err  = err;
            e.data = d;
            e.acc  = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int g);
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && sbq.size() != 0; n++) @(posedge clock);
        #1;
        check("drain", sbq.size(), 0);
    endtask

    // Monitor: latency on rising out_valid, payload on handshake
    always @(negedge clock) begin : mon
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            seen = '0;
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (out_valid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    if (sbq.size() == 0 || sbq[0].inst != g)
                        check($sformatf("unexpected_valid_i%0d", g), 1, 0);
                    else
                        check($sformatf("latency_i%0d", g), cyc - sbq[0].acc, iter_of(g));
                end
                if (out_valid[g] && out_ready[g]) begin
                    seen[g] = 1'b0;
                    if (sbq.size() != 0 && sbq[0].inst == g) begin
                        e = sbq.pop_front();
                        check($sformatf("code_i%0d_d%0d", g, e.data), codeout[g], e.code);
                        check($sformatf("err_i%0d_d%0d", g, e.data), out_err[g], e.err);
                        if (!e.err)
                            check($sformatf("wsum_i%0d_d%0d", g, e.data), wsum(codeout[g]), e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int vec [11];
        int prev;
        int c0;
        int d;
        in_valid  = '0;
        out_ready = '1;
        datain    = '0;
        rst_n     = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_codeout_i0", codeout[0], 0);
        check("rst_codeout_i3", codeout[3], 0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("in_ready_after_release", in_ready, 4'hF);

        // Small values and range boundaries, P=1
        send(0, 0, 18'h00000, 1'b0);
        send(0, 1, 18'h00001, 1'b0);
        send(0, 2, 18'h00003, 1'b0);
        send(0, 4181, 18'h2AAAB, 1'b0);
        send(0, 6764, 18'h3FFFF, 1'b0);
        send(0, 6765, 18'h00000, 1'b1);
        send(0, 8191, 18'h00000, 1'b1);
        idle(0);
        wait_drain();

        // P sweep: same words on every instance, reference model for expected code
        vec[0] = 0;    vec[1] = 1;    vec[2] = 2;    vec[3] = 4181;
        vec[4] = 6764; vec[5] = 6765; vec[6] = 8191; vec[7] = 1000;
        for (int i = 8; i < 11; i++) vec[i] = int'($urandom_range(0, 6764));
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 11; i++) send(g, vec[i], model_enc(vec[i]), vec[i] >= 6765);
            idle(g);
            wait_drain();
        end

        // Streaming: one word every ITER+1 cycles
        for (int g = 0; g < 2; g++) begin
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                d = 100 * i + 37 + g;
                send(g, d, model_enc(d), 1'b0);
                if (i > 0) check($sformatf("stream_gap_i%0d", g), last_acc - prev, iter_of(g) + 1);
                prev = last_acc;
            end
            idle(g);
            wait_drain();
        end

        // Back-pressure in DONE, then accept on the releasing edge
        out_ready[0] = 1'b0;
        send(0, 4181, 18'h2AAAB, 1'b0);
        idle(0);
        for (int n = 0; n < 40 && !out_valid[0]; n++) begin
            @(posedge clock);
            #1;
        end
        for (int n = 0; n < 10; n++) begin
            check("bp_out_valid", out_valid[0], 1);
            check("bp_codeout", codeout[0], 18'h2AAAB);
            check("bp_in_ready", in_ready[0], 0);
            @(posedge clock);
            #1;
        end
        out_ready[0] = 1'b1;
        c0 = cyc;
        send(0, 6764, 18'h3FFFF, 1'b0);
        check("bp_same_edge_accept", last_acc, c0 + 1);
        idle(0);
        wait_drain();

        // Asynchronous reset in the middle of iteration 9
        send(0, 6764, 18'h3FFFF, 1'b0);
        idle(0);
        repeat (9) @(posedge clock);
        #1;
        check("partial_code_iter9", codeout[0], 18'h3FE00);
        rst_n = 1'b0;
        #1;
        check("async_rst_codeout", codeout[0], 0);
        check("async_rst_out_valid", out_valid[0], 0);
        check("async_rst_in_ready", in_ready[0], 0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_out_valid", out_valid[0], 0);
        send(0, 2, 18'h00003, 1'b0);
        idle(0);
        wait_drain();
        repeat (25) @(posedge clock);
        #1;
        check("no_stale_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
